// File: rtl/lsu_initiator.sv
// M-stage load/store unit: issues one handshaked word transaction per load/store and stalls until ack or timeout.
// Optional store trace printing is compiled in when LSU_TRACE_EN is defined.
module lsu_initiator #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread_M,
    input  logic              memwrite_M,
    input  logic [1:0]        size_M,
    input  logic              unsigned_M,
    input  logic [ADDR_W-1:0] data_alu_M,
    input  logic [31:0]       writedata_M,
    input  logic [31:0]       pcout_M,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              stall_M,
    output logic [31:0]       data_dm_M,
    output logic              addr_exc_M,
    output logic              bus_err_M
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;

    logic              req_s;
    logic              mis_s;
    logic              is_store_s;
    logic              bus_req_s;
    logic              stall_s;
    logic              addr_exc_s;
    logic [1:0]        off_s;
    logic [31:0]       load_s;

    function automatic logic [3:0] be_f(input logic st, input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        if (st) begin
            case (sz)
                2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
                2'b10:   be = 4'b0001 << off;
                default: be = 4'b1111;
            endcase
        end else begin
            be = 4'b1111;
        end
        return be;
    endfunction

    function automatic logic [31:0] wdata_f(input logic st, input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        r = 32'h0000_0000;
        if (st) begin
            case (sz)
                2'b01:   r = {2{wd[15:0]}};
                2'b10:   r = {4{wd[7:0]}};
                default: r = wd;
            endcase
        end else begin
            r = 32'h0000_0000;
        end
        return r;
    endfunction

    function automatic logic [31:0] load_f(input logic [31:0] rd, input logic [1:0] sz,
                                           input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            2'b11:   b = rd[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (sz)
            2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            2'b10:   r = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
            default: r = rd;
        endcase
        return r;
    endfunction

    // Request decode, alignment check and bus field generation from the held M-stage inputs
    always_comb begin
        req_s      = memread_M | memwrite_M;
        is_store_s = memwrite_M;
        off_s      = data_alu_M[1:0];
        case (size_M)
            2'b01:   mis_s = off_s[0];
            2'b10:   mis_s = 1'b0;
            default: mis_s = (off_s != 2'b00);
        endcase
        load_s     = load_f(bus_rdata, size_M, off_s, unsigned_M);
    end

    // Next-state logic and per-state outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        err_d      = err_q;
        bus_req_s  = 1'b0;
        stall_s    = 1'b0;
        addr_exc_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                addr_exc_s = req_s & mis_s;
                if (reset && req_s && !mis_s) begin
                    stall_s = 1'b1;
                    state_d = ST_ISSUE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                bus_req_s = 1'b1;
                stall_s   = 1'b1;
                if (bus_ack) begin
                    data_d  = is_store_s ? data_q : load_s;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    data_d  = 32'h0000_0000;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, timeout counter and load result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            data_q  <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign bus_req    = bus_req_s;
    assign stall_M    = stall_s;
    assign addr_exc_M = addr_exc_s;
    assign bus_we     = is_store_s;
    assign bus_addr   = {data_alu_M[ADDR_W-1:2], 2'b00};
    assign bus_be     = be_f(is_store_s, size_M, off_s);
    assign bus_wdata  = wdata_f(is_store_s, size_M, writedata_M);
    assign data_dm_M  = data_q;
    assign bus_err_M  = err_q;

`ifdef LSU_TRACE_EN
    // Store trace at the accepting edge
    always @(posedge clk) begin
        if (reset && state_q == ST_ISSUE && bus_ack && is_store_s) begin
            $display("@%08h: *%08h <= %08h", pcout_M, data_alu_M, bus_wdata);
        end
    end
`else
    logic unused_trace_s;
    assign unused_trace_s = ^pcout_M;
`endif

endmodule

// File: tb/tb_lsu_initiator.sv
// Randomized scoreboard bench for lsu_initiator with a byte-lane reference model.
module tb_lsu_initiator;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memread_M = 1'b0, memwrite_M = 1'b0, unsigned_M = 1'b0;
    logic [1:0]  size_M = 2'b00;
    logic [31:0] data_alu_M = 32'h0, writedata_M = 32'h0, pcout_M = 32'h0;
    logic        bus_req, bus_we, bus_ack = 1'b0;
    logic [31:0] bus_addr, bus_wdata, bus_rdata = 32'h0, data_dm_M;
    logic [3:0]  bus_be;
    logic        stall_M, addr_exc_M, bus_err_M;

    lsu_initiator #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .memread_M(memread_M), .memwrite_M(memwrite_M),
        .size_M(size_M), .unsigned_M(unsigned_M), .data_alu_M(data_alu_M),
        .writedata_M(writedata_M), .pcout_M(pcout_M), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .stall_M(stall_M), .data_dm_M(data_dm_M),
        .addr_exc_M(addr_exc_M), .bus_err_M(bus_err_M)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we; } bus_t;
    typedef struct { int stall; logic [31:0] data; logic err; } done_t;

    bus_t        q_bus[$];
    done_t       q_done[$];
    logic [31:0] model_data = 32'h0;
    logic        model_err = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes_f(input logic [1:0] sz);
        case (sz)
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic mis_f(input logic [1:0] sz, input logic [31:0] a);
        return (a % nbytes_f(sz)) != 0;
    endfunction

    function automatic logic [3:0] be_model(input logic st, input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be;
        int n, off;
        if (!st) return 4'hF;
        be = 4'h0;
        n = nbytes_f(sz);
        off = int'(a % 4);
        for (int i = 0; i < 4; i++) if (i >= off && i < off + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] wd_model(input logic st, input logic [1:0] sz, input logic [31:0] wd);
        if (!st) return 32'h0;
        case (nbytes_f(sz))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ext_model(input logic [31:0] rdat, input logic [1:0] sz,
                                              input logic uns, input logic [31:0] a);
        longint v, span;
        int n, off;
        logic [63:0] r;
        n = nbytes_f(sz);
        off = int'(a % 4);
        span = longint'(1) << (8 * n);
        v = (longint'(rdat) >> (8 * off)) % span;
        if (!uns && v >= span / 2) v = v - span;
        r = 64'(v);
        return r[31:0];
    endfunction

    // Monitor: checks each accepted bus beat and each completed stall window against the queues
    int   stall_cnt = 0;
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            stall_cnt = 0;
            prev_stall = 1'b0;
        end else begin
            if (bus_req && bus_ack) begin
                if (q_bus.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_accept: addr %h with no pending transaction", bus_addr);
                end else begin
                    bus_t e;
                    e = q_bus.pop_front();
                    chk("bus_addr", bus_addr, e.addr);
                    chk("bus_be", {28'h0, bus_be}, {28'h0, e.be});
                    chk("bus_wdata", bus_wdata, e.wdata);
                    chk("bus_we", {31'h0, bus_we}, {31'h0, e.we});
                end
            end
            if (stall_M) begin
                stall_cnt++;
            end else if (prev_stall) begin
                if (q_done.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: stall of %0d cycles with no pending transaction", stall_cnt);
                end else begin
                    done_t d;
                    d = q_done.pop_front();
                    chk("stall_len", 32'(stall_cnt), 32'(d.stall));
                    chk("data_dm", data_dm_M, d.data);
                    chk("bus_err", {31'h0, bus_err_M}, {31'h0, d.err});
                end
                stall_cnt = 0;
            end
            prev_stall = stall_M;
        end
    end

    // One pipeline request; d = ISSUE cycle carrying the ack (0 = never ack)
    task automatic do_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                          input int d);
        bus_t  eb;
        done_t ed;
        int    cyc;
        logic  fin;
        @(posedge clk); #1;
        memread_M = rd; memwrite_M = wr; size_M = sz; unsigned_M = uns;
        data_alu_M = a; writedata_M = wd; pcout_M = $urandom;
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        if (!(rd | wr)) begin
            @(negedge clk);
            chk("idle_stall", {31'h0, stall_M}, 32'h0);
            return;
        end
        if (mis_f(sz, a)) begin
            @(negedge clk);
            chk("mis_exc", {31'h0, addr_exc_M}, 32'h1);
            chk("mis_stall", {31'h0, stall_M}, 32'h0);
            @(posedge clk); #1;
            chk("mis_no_req", {31'h0, bus_req}, 32'h0);
            memread_M = 1'b0; memwrite_M = 1'b0;
            return;
        end
        eb.addr  = a & ~32'h3;
        eb.be    = be_model(wr, sz, a);
        eb.wdata = wd_model(wr, sz, wd);
        eb.we    = wr;
        if (d != 0) begin
            q_bus.push_back(eb);
            if (!wr) model_data = ext_model(rdat, sz, uns, a);
            model_err = 1'b0;
            ed.stall = 1 + d;
        end else begin
            model_data = 32'h0;
            model_err = 1'b1;
            ed.stall = 1 + TO;
        end
        ed.data = model_data;
        ed.err = model_err;
        q_done.push_back(ed);
        @(negedge clk);
        chk("req_no_exc", {31'h0, addr_exc_M}, 32'h0);
        cyc = 0;
        fin = 1'b0;
        while (!fin) begin
            @(posedge clk); #1;
            if (!bus_req) begin
                fin = 1'b1;
            end else begin
                cyc++;
                if (cyc > TO + 2) begin
                    checks++;
                    failures++;
                    $display("FAIL issue_bound: still requesting after %0d cycles", cyc);
                    fin = 1'b1;
                end else begin
                    bus_ack = (cyc == d);
                    bus_rdata = (cyc == d) ? rdat : $urandom;
                end
            end
        end
        bus_ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        chk("no_reissue", {31'h0, bus_req}, 32'h0);
        memread_M = 1'b0; memwrite_M = 1'b0; bus_ack = 1'b0;
    endtask

    initial begin
        memread_M = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req", {31'h0, bus_req}, 32'h0);
        chk("reset_stall", {31'h0, stall_M}, 32'h0);
        chk("reset_dm", data_dm_M, 32'h0);
        chk("reset_err", {31'h0, bus_err_M}, 32'h0);
        memread_M = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        do_txn(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1);
        do_txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h000000A5, 32'h0, 1);
        do_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 32'h12348056, 3);
        do_txn(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h9ABC0000, 2);
        do_txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h06, 32'h0, 32'h0, 1);
        do_txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 32'h11111111, 0);
        do_txn(1'b1, 1'b1, 2'b01, 1'b0, 32'h36, 32'hCAFE1234, 32'h0, TO);
        do_txn(1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 32'h87654321, 1);

        // Reset asserted in the middle of ISSUE
        @(posedge clk); #1;
        memread_M = 1'b1; memwrite_M = 1'b0; size_M = 2'b00; data_alu_M = 32'h80; bus_ack = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid_req_before", {31'h0, bus_req}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("mid_req_drop", {31'h0, bus_req}, 32'h0);
        chk("mid_stall_drop", {31'h0, stall_M}, 32'h0);
        chk("mid_dm_clear", data_dm_M, 32'h0);
        model_data = 32'h0;
        model_err = 1'b0;
        memread_M = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        for (int n = 0; n < 150; n++) begin
            logic rd, wr;
            int   r, d;
            r = int'($urandom_range(0, 9));
            rd = 1'b0; wr = 1'b0;
            if (r != 0) begin
                rd = 1'($urandom_range(0, 1));
                wr = 1'($urandom_range(0, 1));
                if (!rd && !wr) rd = 1'b1;
            end
            r = int'($urandom_range(0, 9));
            if (r == 0)      d = 0;
            else if (r == 1) d = TO;
            else             d = int'($urandom_range(1, 4));
            do_txn(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom, d);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("q_bus_empty", 32'(q_bus.size()), 32'h0);
        chk("q_done_empty", 32'(q_done.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_initiator.md
Name: lsu_initiator

Overview:
- M-stage load/store unit: the requesting end of the data-memory interface.
- Takes the pipeline's load/store request and issues one handshaked word transaction to a memory responder.
- Generates byte enables and replicated write data; aligns and sign- or zero-extends load data.
- Stalls the pipeline until the responder acknowledges, or until a timeout expires.

Parameters:
- TIMEOUT, 16: max cycles in ISSUE without bus_ack before abort; must be >= 2.
- ADDR_W, 32: address width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- memread_M  input  1  load in M stage.
- memwrite_M  input  1  store in M stage.
- size_M  input  2  00 word, 01 half, 10 byte, 11 treated as word.
- unsigned_M  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- data_alu_M  input  ADDR_W  byte address.
- writedata_M  input  32  store data, right-justified.
- pcout_M  input  32  PC of M-stage instruction, used only for trace.
- bus_req  output  1  transaction request.
- bus_we  output  1  1 = write.
- bus_addr  output  ADDR_W  word-aligned address {data_alu_M[ADDR_W-1:2], 2'b00}.
- bus_be  output  4  byte enables; bit0 = rdata/wdata[7:0] (little-endian).
- bus_wdata  output  32  write data.
- bus_ack  input  1  responder accept; bus_rdata valid in the same cycle.
- bus_rdata  input  32  read word.
- stall_M  output  1  hold M stage and upstream.
- data_dm_M  output  32  extended load result.
- addr_exc_M  output  1  misaligned access, combinational.
- bus_err_M  output  1  timeout abort flag.

Behaviour:
- States: IDLE, ISSUE, DONE. Encoding and state register are private to the block.
- req = memread_M | memwrite_M. If both are high, the access is a store.
- mis = (size word and addr[1:0] != 0) | (size half and addr[0] != 0).
- IDLE:
  - addr_exc_M = req & mis. A misaligned request issues no bus cycle, raises no stall and stays in IDLE.
  - req & !mis: stall_M = 1 combinationally; go to ISSUE next edge; clear timeout counter.
  - bus_req = 0.
- ISSUE:
  - bus_req = 1 and stall_M = 1.
  - bus_we, bus_addr, bus_be and bus_wdata derive from the M-stage inputs, which the pipeline holds stable under stall.
  - bus_ack = 1: latch the extended load result (stores: data_dm_M unchanged), clear bus_err_M, go to DONE.
  - No ack after TIMEOUT cycles in ISSUE: set bus_err_M = 1, data_dm_M = 0, go to DONE.
  - Minimum latency: request cycle (IDLE) + 1 ISSUE cycle + DONE, i.e. the stall lasts 2 cycles with a same-cycle ack.
- DONE:
  - stall_M = 0 and bus_req = 0; the pipeline advances this cycle.
  - Inputs are ignored, so there is no re-issue. Always go to IDLE next edge.
- bus_ack outside ISSUE is ignored.
- Byte enables and write data:
  - sw: bus_be = 1111, bus_wdata = writedata_M.
  - sh: bus_be = addr[1] ? 1100 : 0011; bus_wdata = {2{writedata_M[15:0]}}.
  - sb: bus_be = 0001 << addr[1:0]; bus_wdata = {4{writedata_M[7:0]}}.
  - Loads: bus_be = 1111; bus_wdata = 0.
- Load extraction:
  - Byte = bus_rdata[8*addr[1:0] +: 8].
  - Half = bus_rdata[16*addr[1] +: 16].
  - Extend to 32 bits per unsigned_M.
- data_dm_M and bus_err_M are registered and hold until the next completed transaction.
- Reset (reset = 0, any time, including mid-ISSUE):
  - Immediately state = IDLE.
  - bus_req = 0, stall_M = 0, data_dm_M = 0, bus_err_M = 0, timeout counter = 0.
  - Combinational outputs follow the IDLE rules.

Optional Feature:
- Macro LSU_TRACE_EN.
  - Defined: on each store accepted by bus_ack, print "@<pcout_M hex>: *<data_alu_M hex> <= <bus_wdata hex>" (8-digit hex each).
  - Not defined: no display statements are compiled; behaviour is otherwise identical.

Test Plan:
- Reset with memread_M = 1: bus_req = 0, stall_M = 0, data_dm_M = 0 while reset = 0.
- sw addr 0x10, data 0xDEADBEEF, ack in the first ISSUE cycle -> bus_addr 0x10, bus_be 1111, bus_wdata 0xDEADBEEF; stall_M high exactly 2 cycles.
- sb addr 0x13, data 0x000000A5 -> bus_be 1000, bus_wdata 0xA5A5A5A5.
- lb addr 0x21 with bus_rdata 0x12348056, ack after 3 cycles -> data_dm_M 0xFFFFFF80; stall_M high 4 cycles.
- lhu addr 0x22 with bus_rdata 0x9ABC0000 -> data_dm_M 0x00009ABC.
- lw addr 0x06 -> addr_exc_M = 1, bus_req never rises, stall_M = 0.
- Load with no ack -> bus_err_M = 1 and data_dm_M = 0 after TIMEOUT = 16 ISSUE cycles.
- Assert reset mid-ISSUE -> bus_req drops the same cycle.
